// File: rtl/ad9958_spi_responder_if.sv
// AD9958 serial-port pin bundle: SPI pins plus the I/O update and master reset strobes.
// The controller drives every pin (master); the responder only observes them (slave).
interface ad9958_spi_responder_if;
   logic       dds_sclk;
   logic       dds_cs_n;
   logic [3:0] dds_sdio;
   logic       dds_master_reset;
   logic       dds_io_update;

   modport master (
      output dds_sclk, dds_cs_n, dds_sdio, dds_master_reset, dds_io_update
   );

   modport slave (
      input dds_sclk, dds_cs_n, dds_sdio, dds_master_reset, dds_io_update
   );
endinterface

// File: rtl/ad9958_spi_responder.sv
// Device-side model of the AD9958 serial write port: oversamples the pins, decodes
// instruction/data frames into per-channel shadows and commits them on I/O update.
//
// Pin bundle (pins): every pin is level-sampled through SYNC_STAGES flops; there is no
// valid/ready handshake. A frame is qualified by dds_cs_n low, each data group is
// qualified by a synchronized dds_sclk rise, and dds_io_update acts on its rising edge.
module ad9958_spi_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   ad9958_spi_responder_if.slave pins,
   output logic [7:0]            csr,
   output logic [23:0]           fr1,
   output logic [15:0]           fr2,
   output logic [23:0]           cfr_ch0,
   output logic [23:0]           cfr_ch1,
   output logic [31:0]           ftw_ch0,
   output logic [31:0]           ftw_ch1,
   output logic [23:0]           acr_ch0,
   output logic [23:0]           acr_ch1,
   output logic                  write_done,
   output logic [4:0]            write_addr,
   output logic                  frame_error,
   output logic [1:0]            dbg_state_o
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_INSTR = 2'd1, S_DATA = 2'd2, S_DISCARD = 2'd3} state_e;

   // Synchronizer lane layout: {io_update, master_reset, cs_n, sclk, sdio[3:0]}
   localparam logic [7:0]  PIN_IDLE    = 8'h20;
   localparam logic [7:0]  CSR_DEFAULT = 8'hF0;
   localparam logic [23:0] CFR_DEFAULT = 24'h000302;

   function automatic logic [2:0] reg_len(input logic [4:0] a);
      case (a)
         5'h00:   reg_len = 3'd1;
         5'h01:   reg_len = 3'd3;
         5'h02:   reg_len = 3'd2;
         5'h03:   reg_len = 3'd3;
         5'h04:   reg_len = 3'd4;
         5'h05:   reg_len = 3'd2;
         5'h06:   reg_len = 3'd3;
         default: reg_len = 3'd0;
      endcase
   endfunction

   logic [SYNC_STAGES-1:0][7:0] pin_sync_q;
   logic [7:0] pin_s;
   logic       sclk_prev_q, iou_prev_q;
   logic       sclk_rise, iou_rise, cs_s, mr_s;
   logic [3:0] sdio_s;

   always_ff @(posedge clock) begin
      if (reset) begin
         pin_sync_q  <= {SYNC_STAGES{PIN_IDLE}};
         sclk_prev_q <= 1'b0;
         iou_prev_q  <= 1'b0;
      end else begin
         pin_sync_q  <= {pin_sync_q[SYNC_STAGES-2:0], pins.dds_io_update, pins.dds_master_reset,
                         pins.dds_cs_n, pins.dds_sclk, pins.dds_sdio};
         sclk_prev_q <= pin_s[4];
         iou_prev_q  <= pin_s[7];
      end
   end

   assign pin_s     = pin_sync_q[SYNC_STAGES-1];
   assign sdio_s    = pin_s[3:0];
   assign sclk_rise = pin_s[4] & ~sclk_prev_q;
   assign cs_s      = pin_s[5];
   assign mr_s      = pin_s[6];
   assign iou_rise  = pin_s[7] & ~iou_prev_q;

   state_e      state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] shift_q, shift_d;
   logic [4:0]  addr_q, addr_d;
   logic [2:0]  len_q, len_d;
   logic [7:0]  csr_q, csr_d;
   logic [23:0] fr1_sh_q, fr1_sh_d, fr1_q, fr1_d;
   logic [15:0] fr2_sh_q, fr2_sh_d, fr2_q, fr2_d;
   logic [23:0] cfr0_sh_q, cfr0_sh_d, cfr0_q, cfr0_d;
   logic [23:0] cfr1_sh_q, cfr1_sh_d, cfr1_q, cfr1_d;
   logic [31:0] ftw0_sh_q, ftw0_sh_d, ftw0_q, ftw0_d;
   logic [31:0] ftw1_sh_q, ftw1_sh_d, ftw1_q, ftw1_d;
   logic [23:0] acr0_sh_q, acr0_sh_d, acr0_q, acr0_d;
   logic [23:0] acr1_sh_q, acr1_sh_d, acr1_q, acr1_d;
   logic        write_done_q, write_done_d;
   logic [4:0]  write_addr_q, write_addr_d;
   logic        frame_error_q, frame_error_d;

   logic        wide, lsb_first;
   logic [5:0]  cnt_next;
   logic [31:0] word_v;

   assign wide      = (csr_q[2:1] == 2'b11);
   assign lsb_first = csr_q[0];

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      addr_d        = addr_q;
      len_d         = len_q;
      csr_d         = csr_q;
      fr1_sh_d      = fr1_sh_q;
      fr2_sh_d      = fr2_sh_q;
      cfr0_sh_d     = cfr0_sh_q;
      cfr1_sh_d     = cfr1_sh_q;
      ftw0_sh_d     = ftw0_sh_q;
      ftw1_sh_d     = ftw1_sh_q;
      acr0_sh_d     = acr0_sh_q;
      acr1_sh_d     = acr1_sh_q;
      fr1_d         = fr1_q;
      fr2_d         = fr2_q;
      cfr0_d        = cfr0_q;
      cfr1_d        = cfr1_q;
      ftw0_d        = ftw0_q;
      ftw1_d        = ftw1_q;
      acr0_d        = acr0_q;
      acr1_d        = acr1_q;
      write_done_d  = 1'b0;
      write_addr_d  = write_addr_q;
      frame_error_d = 1'b0;
      cnt_next      = bit_cnt_q + (wide ? 6'd4 : 6'd1);

      // The word is always assembled in the low bits; shift_q is cleared at each word start
      word_v = shift_q;
      if (lsb_first) begin
         if (wide) word_v[bit_cnt_q[4:0] +: 4] = sdio_s;
         else      word_v[bit_cnt_q[4:0]]      = sdio_s[0];
      end else begin
         word_v = wide ? {shift_q[27:0], sdio_s} : {shift_q[30:0], sdio_s[0]};
      end

      case (state_q)
         S_IDLE: begin
            if (!cs_s) begin
               state_d   = S_INSTR;
               bit_cnt_d = '0;
               shift_d   = '0;
            end
         end
         S_INSTR, S_DATA: begin
            if (cs_s) begin
               state_d       = S_IDLE;
               bit_cnt_d     = '0;
               shift_d       = '0;
               frame_error_d = (bit_cnt_q != 6'd0);
            end else if (sclk_rise) begin
               bit_cnt_d = cnt_next;
               shift_d   = word_v;
               if (state_q == S_INSTR) begin
                  if (cnt_next == 6'd8) begin
                     bit_cnt_d = '0;
                     shift_d   = '0;
                     if (word_v[7] || (reg_len(word_v[4:0]) == 3'd0)) begin
                        frame_error_d = 1'b1;
                        state_d       = S_DISCARD;
                     end else begin
                        addr_d  = word_v[4:0];
                        len_d   = reg_len(word_v[4:0]);
                        state_d = S_DATA;
                     end
                  end
               end else if (cnt_next == {len_q, 3'b000}) begin
                  bit_cnt_d    = '0;
                  shift_d      = '0;
                  state_d      = S_INSTR;
                  write_done_d = 1'b1;
                  write_addr_d = addr_q;
                  case (addr_q)
                     5'h00: csr_d    = word_v[7:0];
                     5'h01: fr1_sh_d = word_v[23:0];
                     5'h02: fr2_sh_d = word_v[15:0];
                     5'h03: begin
                        if (csr_q[6]) cfr0_sh_d = word_v[23:0];
                        if (csr_q[7]) cfr1_sh_d = word_v[23:0];
                     end
                     5'h04: begin
                        if (csr_q[6]) ftw0_sh_d = word_v;
                        if (csr_q[7]) ftw1_sh_d = word_v;
                     end
                     5'h06: begin
                        if (csr_q[6]) acr0_sh_d = word_v[23:0];
                        if (csr_q[7]) acr1_sh_d = word_v[23:0];
                     end
                     default: ;
                  endcase
               end
            end
         end
         S_DISCARD: begin
            if (cs_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Commit from the shadow next-values so a write finishing this cycle is included
      if (iou_rise) begin
         fr1_d  = fr1_sh_d;
         fr2_d  = fr2_sh_d;
         cfr0_d = cfr0_sh_d;
         cfr1_d = cfr1_sh_d;
         ftw0_d = ftw0_sh_d;
         ftw1_d = ftw1_sh_d;
         acr0_d = acr0_sh_d;
         acr1_d = acr1_sh_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || mr_s) begin
         state_q       <= S_IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         csr_q         <= CSR_DEFAULT;
         fr1_sh_q      <= '0;
         fr2_sh_q      <= '0;
         cfr0_sh_q     <= CFR_DEFAULT;
         cfr1_sh_q     <= CFR_DEFAULT;
         ftw0_sh_q     <= '0;
         ftw1_sh_q     <= '0;
         acr0_sh_q     <= '0;
         acr1_sh_q     <= '0;
         fr1_q         <= '0;
         fr2_q         <= '0;
         cfr0_q        <= CFR_DEFAULT;
         cfr1_q        <= CFR_DEFAULT;
         ftw0_q        <= '0;
         ftw1_q        <= '0;
         acr0_q        <= '0;
         acr1_q        <= '0;
         write_done_q  <= 1'b0;
         write_addr_q  <= '0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         addr_q        <= addr_d;
         len_q         <= len_d;
         csr_q         <= csr_d;
         fr1_sh_q      <= fr1_sh_d;
         fr2_sh_q      <= fr2_sh_d;
         cfr0_sh_q     <= cfr0_sh_d;
         cfr1_sh_q     <= cfr1_sh_d;
         ftw0_sh_q     <= ftw0_sh_d;
         ftw1_sh_q     <= ftw1_sh_d;
         acr0_sh_q     <= acr0_sh_d;
         acr1_sh_q     <= acr1_sh_d;
         fr1_q         <= fr1_d;
         fr2_q         <= fr2_d;
         cfr0_q        <= cfr0_d;
         cfr1_q        <= cfr1_d;
         ftw0_q        <= ftw0_d;
         ftw1_q        <= ftw1_d;
         acr0_q        <= acr0_d;
         acr1_q        <= acr1_d;
         write_done_q  <= write_done_d;
         write_addr_q  <= write_addr_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign csr         = csr_q;
   assign fr1         = fr1_q;
   assign fr2         = fr2_q;
   assign cfr_ch0     = cfr0_q;
   assign cfr_ch1     = cfr1_q;
   assign ftw_ch0     = ftw0_q;
   assign ftw_ch1     = ftw1_q;
   assign acr_ch0     = acr0_q;
   assign acr_ch1     = acr1_q;
   assign write_done  = write_done_q;
   assign write_addr  = write_addr_q;
   assign frame_error = frame_error_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ad9958_spi_responder.sv
// Directed bench for ad9958_spi_responder: drives controller-style SPI frames and checks
// write/error pulses through an expected-event queue plus register values after commits.
module tb_ad9958_spi_responder;
   localparam int SYNC_STAGES = 2;
   localparam logic [5:0] EV_ERR = 6'h20;

   logic        clock;
   logic        reset;
   logic [7:0]  csr;
   logic [23:0] fr1, cfr_ch0, cfr_ch1, acr_ch0, acr_ch1;
   logic [15:0] fr2;
   logic [31:0] ftw_ch0, ftw_ch1;
   logic        write_done, frame_error;
   logic [4:0]  write_addr;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;
   logic [5:0] exp_q[$];
   logic mode_wide = 1'b0;
   logic mode_lsb  = 1'b0;

   ad9958_spi_responder_if pins_if ();

   ad9958_spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clock       (clock),
      .reset       (reset),
      .pins        (pins_if.slave),
      .csr         (csr),
      .fr1         (fr1),
      .fr2         (fr2),
      .cfr_ch0     (cfr_ch0),
      .cfr_ch1     (cfr_ch1),
      .ftw_ch0     (ftw_ch0),
      .ftw_ch1     (ftw_ch1),
      .acr_ch0     (acr_ch0),
      .acr_ch1     (acr_ch1),
      .write_done  (write_done),
      .write_addr  (write_addr),
      .frame_error (frame_error),
      .dbg_state_o (dbg_state)
   );

   // Clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running after time limit");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic sclk_beat(input logic [3:0] d);
      pins_if.dds_sdio = d;
      tick(3);
      pins_if.dds_sclk = 1'b1;
      tick(3);
      pins_if.dds_sclk = 1'b0;
   endtask

   task automatic send(input logic [31:0] v, input int nbits);
      int step;
      step = mode_wide ? 4 : 1;
      for (int i = 0; i < nbits / step; i++) begin
         logic [3:0] d;
         if (mode_lsb) d = mode_wide ? v[i*4 +: 4] : {3'b000, v[i]};
         else          d = mode_wide ? v[nbits-4-4*i +: 4] : {3'b000, v[nbits-1-i]};
         sclk_beat(d);
      end
   endtask

   task automatic write_reg(input logic [4:0] addr, input logic [31:0] v, input int nbytes);
      exp_q.push_back({1'b0, addr});
      send({27'd0, addr}, 8);
      send(v, nbytes * 8);
      if (addr == 5'h00) begin
         mode_wide = (v[2:1] == 2'b11);
         mode_lsb  = v[0];
      end
   endtask

   task automatic cs_low();
      pins_if.dds_cs_n = 1'b0;
      tick(4);
   endtask

   task automatic cs_high();
      tick(3);
      pins_if.dds_cs_n = 1'b1;
      tick(6);
   endtask

   // Raise io_update and stop one clock short of the commit edge
   task automatic iou_rise();
      pins_if.dds_io_update = 1'b1;
      tick(SYNC_STAGES);
   endtask

   task automatic iou_finish();
      tick(1);
      pins_if.dds_io_update = 1'b0;
      tick(4);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick(1);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s: %0d expected events never seen, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Scoreboard monitor
   always @(negedge clock) begin
      if (!reset && (write_done || frame_error)) begin
         logic [5:0] act;
         logic [5:0] exp;
         act = write_done ? {1'b0, write_addr} : EV_ERR;
         total++;
         if (write_done && frame_error) begin
            bad++;
            $display("FAIL event_both: write_done and frame_error together, want one");
         end else if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event_unexpected: got event 0x%02h, want none", act);
         end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
               bad++;
               $display("FAIL event_order: got event 0x%02h, want 0x%02h", act, exp);
            end
         end
      end
   end

   initial begin
      pins_if.dds_sclk         = 1'b0;
      pins_if.dds_cs_n         = 1'b1;
      pins_if.dds_sdio         = 4'h0;
      pins_if.dds_master_reset = 1'b0;
      pins_if.dds_io_update    = 1'b0;
      reset = 1'b1;
      tick(5);
      reset = 1'b0;
      tick(10);

      check("rst_csr", {24'd0, csr}, 32'hF0);
      check("rst_fr1", {8'd0, fr1}, 32'h0);
      check("rst_fr2", {16'd0, fr2}, 32'h0);
      check("rst_cfr0", {8'd0, cfr_ch0}, 32'h000302);
      check("rst_cfr1", {8'd0, cfr_ch1}, 32'h000302);
      check("rst_ftw0", ftw_ch0, 32'h0);
      check("rst_ftw1", ftw_ch1, 32'h0);
      check("rst_acr0", {8'd0, acr_ch0}, 32'h0);
      check("rst_acr1", {8'd0, acr_ch1}, 32'h0);
      check("rst_pulses", {30'd0, write_done, frame_error}, 32'h0);
      check("rst_waddr", {27'd0, write_addr}, 32'h0);

      // CSR in 1-bit MSB-first: direct, no I/O update needed
      cs_low();
      write_reg(5'h00, 32'h47, 1);
      wait_drain("drain_csr");
      check("csr_direct", {24'd0, csr}, 32'h47);

      // FTW in 4-bit LSB-first, CH0 only; active only after I/O update
      write_reg(5'h04, 32'h12345678, 4);
      wait_drain("drain_ftw");
      check("ftw0_shadow_only", ftw_ch0, 32'h0);
      iou_rise();
      check("ftw0_pre_commit", ftw_ch0, 32'h0);
      tick(1);
      check("ftw0_commit", ftw_ch0, 32'h12345678);
      check("ftw1_untouched", ftw_ch1, 32'h0);
      pins_if.dds_io_update = 1'b0;
      tick(4);

      // Controller sequence under the same CS-low
      write_reg(5'h00, 32'h47, 1);
      write_reg(5'h04, 32'h11111111, 4);
      write_reg(5'h00, 32'h87, 1);
      write_reg(5'h04, 32'h22222222, 4);
      wait_drain("drain_seq");
      check("seq_csr", {24'd0, csr}, 32'h87);
      iou_rise();
      check("seq_ftw0_pre", ftw_ch0, 32'h12345678);
      check("seq_ftw1_pre", ftw_ch1, 32'h0);
      tick(1);
      check("seq_ftw0", ftw_ch0, 32'h11111111);
      check("seq_ftw1", ftw_ch1, 32'h22222222);
      pins_if.dds_io_update = 1'b0;
      tick(4);
      cs_high();

      // Read instruction, then unknown address, then a good frame
      cs_low();
      exp_q.push_back(EV_ERR);
      send(32'h84, 8);
      send(32'hA5, 8);
      wait_drain("drain_read_err");
      cs_high();
      cs_low();
      exp_q.push_back(EV_ERR);
      send(32'h0A, 8);
      wait_drain("drain_addr_err");
      cs_high();
      cs_low();
      write_reg(5'h02, 32'hBEEF, 2);
      wait_drain("drain_fr2");
      cs_high();
      iou_rise();
      iou_finish();
      check("fr2_after_errors", {16'd0, fr2}, 32'hBEEF);

      // CS raised after 2 of 4 FTW bytes
      cs_low();
      send(32'h04, 8);
      send(32'hAAAA, 16);
      exp_q.push_back(EV_ERR);
      cs_high();
      wait_drain("drain_partial");
      iou_rise();
      iou_finish();
      check("partial_ftw1", ftw_ch1, 32'h22222222);
      check("partial_ftw0", ftw_ch0, 32'h11111111);

      // Master reset in the middle of a FR1 data phase
      cs_low();
      send(32'h01, 8);
      send(32'h00000ABC, 12);
      pins_if.dds_master_reset = 1'b1;
      tick(6);
      pins_if.dds_master_reset = 1'b0;
      tick(6);
      mode_wide = 1'b0;
      mode_lsb  = 1'b0;
      check("mr_csr", {24'd0, csr}, 32'hF0);
      check("mr_fr1", {8'd0, fr1}, 32'h0);
      check("mr_fr2", {16'd0, fr2}, 32'h0);
      check("mr_ftw0", ftw_ch0, 32'h0);
      check("mr_ftw1", ftw_ch1, 32'h0);
      check("mr_cfr0", {8'd0, cfr_ch0}, 32'h000302);
      cs_high();

      // After master reset: 1-bit MSB-first, both channels enabled
      cs_low();
      write_reg(5'h03, 32'h123456, 3);
      cs_high();
      wait_drain("drain_cfr");
      check("cfr0_shadow_only", {8'd0, cfr_ch0}, 32'h000302);
      iou_rise();
      iou_finish();
      check("cfr0_commit", {8'd0, cfr_ch0}, 32'h123456);
      check("cfr1_commit", {8'd0, cfr_ch1}, 32'h123456);

      tick(10);
      wait_drain("final_drain");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ad9958_spi_responder.md
# ad9958_spi_responder

Synthesizable AD9958 serial-port responder, the device-side counterpart of the DDS controller's write path. It oversamples the SPI pins (`dds_sclk`, `dds_cs_n`, `dds_sdio`) together with `dds_io_update` and `dds_master_reset`. It decodes instruction and data frames in 2-wire 1-bit or 4-bit serial mode, MSB- or LSB-first, into per-channel shadow registers, and commits them to active registers on I/O update. It sits in the loopback and bench fabric in place of the real DDS, so controller sequences can be checked cycle-accurately on hardware and in simulation.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on all pin inputs, 2..3.
- `clock` in 1: system clock; must be at least 4× the `dds_sclk` frequency.
- `reset` in 1: synchronous, active-high; same effect as master reset.
- `dds_sclk` in 1: serial clock; data is captured on its rising edge.
- `dds_cs_n` in 1: chip select, active-low.
- `dds_sdio` in 4: serial data; bit 0 only in 1-bit mode.
- `dds_master_reset` in 1: async pin, level-active; synchronized before use.
- `dds_io_update` in 1: async pin; its rising edge commits the shadow registers.
- `csr` out 8: channel select register; not buffered.
- `fr1` out 24: active FR1.
- `fr2` out 16: active FR2.
- `cfr_ch0`, `cfr_ch1` out 24: active CFR for each channel.
- `ftw_ch0`, `ftw_ch1` out 32: active CFTW0 for each channel.
- `acr_ch0`, `acr_ch1` out 24: active ACR for each channel.
- `write_done` out 1: one-cycle pulse when a data phase completes.
- `write_addr` out 5: address of the last completed write; valid with `write_done`.
- `frame_error` out 1: one-cycle pulse on any protocol error.

## Operation
- Synchronization: all five pins pass through `SYNC_STAGES` flops.
  - An SCLK rise is detected when the synchronized value is 1 and it was 0 the previous cycle.
  - `dds_sdio` is sampled from the same synchronizer stage as SCLK.
- CSR fields:
  - [7] enables CH1; [6] enables CH0.
  - [2:1] select the I/O mode: 00 = 1-bit, 11 = 4-bit; 01 and 10 are treated as 1-bit.
  - [0] selects LSB-first.
- Bits per SCLK: 1 in 1-bit mode, 4 in 4-bit mode.
- Bit order, MSB-first: each SCLK shifts in the next most-significant bits. In 4-bit mode `dds_sdio[3]` is the higher bit.
- Bit order, LSB-first: each SCLK fills the next least-significant bits, `dds_sdio[0]` lowest.
- Bit order applies to the whole word, including the instruction byte.
- States: IDLE, INSTR, DATA, DISCARD.
- IDLE:
  - `dds_cs_n` low moves to INSTR; the bit counter clears.
- INSTR (8 bits collected):
  - Bit 7 set (read) gives `frame_error` and moves to DISCARD.
  - Otherwise address = bits [4:0], and the expected length is loaded.
- Register lengths by address:
  - 0x00 CSR = 1 byte; 0x01 FR1 = 3; 0x02 FR2 = 2; 0x03 CFR = 3.
  - 0x04 CFTW0 = 4; 0x05 CPOW0 = 2; 0x06 ACR = 3.
  - Any other address gives `frame_error` and moves to DISCARD.
- DATA:
  - When `len*8` bits are collected, the word is written, `write_done` pulses with `write_addr`, and the state returns to INSTR without a CS toggle.
  - CSR is written directly to `csr`. The new mode takes effect from the next instruction bit.
  - FR1 and FR2 go to their shadows.
  - CFR, CFTW0 and ACR go to the shadow of every channel enabled in `csr`. If neither channel is enabled, the data is dropped without error.
  - CPOW0 is accepted and discarded.
- DISCARD: ignores SCLK until `dds_cs_n` goes high.
- `dds_cs_n` high in any state returns to IDLE.
  - A partial INSTR or DATA frame (non-zero bit count) is dropped and pulses `frame_error`.
- I/O update: on a synchronized rising edge, every shadow register is copied to its active output in one cycle.
  - A write completing in the same cycle is included in the commit (the shadow's next value is bypassed to the active output).
- Master reset (synchronized level high) or `reset`:
  - All shadow and active registers take their defaults; state returns to IDLE; the bit counter clears.
  - While the source is held high, the state stays IDLE.

## Timing
- Reset values:
  - `csr` = 0xF0; `fr1` = 0; `fr2` = 0.
  - `cfr_ch*` = 0x000302.
  - `ftw_ch*` = 0; `acr_ch*` = 0.
  - `write_done`, `write_addr` and `frame_error` = 0.
- Pin-to-capture latency is `SYNC_STAGES`+1 clocks after an SCLK pin rise.
- `write_done` asserts in the clock after the capture of the final bit. Data reaches the shadow (or `csr`) in the same edge.
- Active outputs update `SYNC_STAGES`+1 clocks after the `dds_io_update` pin rise.
- `dds_sdio` must be stable for at least 2 clocks around each SCLK rise.
- An SCLK rise coincident with `dds_cs_n` going high is ignored.

## Test plan
- Reset, then idle 10 clocks -> `csr`=0xF0, `cfr_ch0`=`cfr_ch1`=0x000302, all others 0, no pulses.
- In 1-bit MSB-first mode, send 0x00 then 0x47 -> `write_done` with `write_addr`=0; `csr`=0x47 immediately, with no I/O update.
- In 4-bit LSB-first mode with CH0 only, send instruction 0x04 then 0x12345678 -> `ftw_ch0` stays 0. After an I/O update, `ftw_ch0`=0x12345678 and `ftw_ch1`=0.
- Controller-style sequence, all in 4-bit LSB-first mode and under one CS-low:
  - CSR=0x47, FTW=0x11111111; then CSR=0x87, FTW=0x22222222; then an I/O update.
  - Required result: `ftw_ch0`=0x11111111 and `ftw_ch1`=0x22222222, committed in the same cycle.
- Instruction 0x84, then unknown address 0x0A -> each gives a `frame_error` pulse and no `write_done`; the next frame after a CS toggle decodes correctly.
- Raise `dds_cs_n` after 2 of the 4 FTW bytes -> `frame_error` pulses and the shadow is unchanged.
- Assert `dds_master_reset` mid-DATA -> defaults restored and no `write_done`.
